// File: rtl/zstr_fifo_pkg.sv
// ----------------------------------------------------------------------------
// zstr_fifo_pkg
// Shared zbus helpers used by the zstr FIFO slice.
//   zbus_xfer  : transfer qualifier, a word moves when vld & ack are both high
//   zbus_clog2 : ceiling log2, used to size pointers from DEPTH
// No typedefs are needed; the grouped bus is an opaque BW-bit vector.
// ----------------------------------------------------------------------------
package zstr_fifo_pkg;

  // A zbus transfer happens on a rising edge where both qualifiers are high.
  function automatic logic zbus_xfer(input logic vld, input logic ack);
    return vld & ack;
  endfunction

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int zbus_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/zstr_fifo_mem.sv
// ----------------------------------------------------------------------------
// zstr_fifo_mem
// DEPTH x BW register array with synchronous write and asynchronous read.
// Contents are not reset.
// Ports:
//   z_clk    : clock, writes on the rising edge
//   wr_en    : write strobe
//   wr_addr  : write address (AW bits)
//   wr_data  : write data (BW bits)
//   rd_addr  : read address (AW bits)
//   rd_data  : read data, combinational from the addressed entry
// ----------------------------------------------------------------------------
module zstr_fifo_mem #(
  parameter int BW    = 1,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          z_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [BW-1:0] rd_data
);

  logic [BW-1:0] rd_vec [DEPTH];

  // Each entry owns its own register so every storage bit has one driver.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [BW-1:0] entry_reg;

      always_ff @(posedge z_clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign rd_vec[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = rd_vec[rd_addr];

endmodule

// File: rtl/zstr_fifo.sv
// ----------------------------------------------------------------------------
// zstr_fifo
// Synchronous FIFO terminating an upstream zstr stream and re-emitting it
// downstream. Absorbs bursts of up to DEPTH words; one cycle write-to-read
// latency, no fall-through.
// Parameters:
//   BW    : width of the grouped bus
//   DEPTH : number of entries, power of two, >= 2
// Ports:
//   z_clk  : clock
//   z_rst  : synchronous active-high reset
//   zi_vld : upstream valid
//   zi_bus : upstream data
//   zi_ack : upstream acknowledge (not full)
//   zo_vld : downstream valid (not empty)
//   zo_bus : downstream data (head entry)
//   zo_ack : downstream acknowledge
//   z_cnt  : fill level 0..DEPTH
// ----------------------------------------------------------------------------
module zstr_fifo
  import zstr_fifo_pkg::*;
#(
  parameter int BW    = 1,
  parameter int DEPTH = 4
) (
  input  logic                         z_clk,
  input  logic                         z_rst,
  input  logic                         zi_vld,
  input  logic [BW-1:0]                zi_bus,
  output logic                         zi_ack,
  output logic                         zo_vld,
  output logic [BW-1:0]                zo_bus,
  input  logic                         zo_ack,
  output logic [zbus_clog2(DEPTH):0]   z_cnt
);

  localparam int AW = zbus_clog2(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   cnt_reg;
  logic [AW:0]   cnt_next;
  logic          wr_en;
  logic          rd_en;
  logic          mem_wr_en;

  // Handshake flags come only from the registered count, so there is no
  // combinational path from zi_vld/zo_ack back to zi_ack/zo_vld.
  assign zi_ack = (cnt_reg != (AW+1)'(DEPTH));
  assign zo_vld = (cnt_reg != '0);
  assign z_cnt  = cnt_reg;

  assign wr_en = zbus_xfer(zi_vld, zi_ack);
  assign rd_en = zbus_xfer(zo_vld, zo_ack);

  // A write presented on a reset edge is discarded along with everything else.
  assign mem_wr_en = wr_en & ~z_rst;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    // Pointers wrap naturally at AW bits since DEPTH is a power of two.
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_next = cnt_reg + (AW+1)'(1);
      2'b01:   cnt_next = cnt_reg - (AW+1)'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge z_clk) begin
    if (z_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  zstr_fifo_mem #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .z_clk   (z_clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (zi_bus),
    .rd_addr (rd_ptr_reg),
    .rd_data (zo_bus)
  );

endmodule

// File: tb/tb_zstr_fifo.sv
// ----------------------------------------------------------------------------
// tb_zstr_fifo
// Self-checking bench for zstr_fifo with BW=8, DEPTH=4. A queue models the
// FIFO contents; acceptance and delivery are decided from the queue size.
// Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_zstr_fifo;

  localparam int BW    = 8;
  localparam int DEPTH = 4;

  logic          z_clk;
  logic          z_rst;
  logic          zi_vld;
  logic [BW-1:0] zi_bus;
  logic          zi_ack;
  logic          zo_vld;
  logic [BW-1:0] zo_bus;
  logic          zo_ack;
  logic [2:0]    z_cnt;

  int checks;
  int failures;

  logic [BW-1:0] model_q [$];

  zstr_fifo #(
    .BW    (BW),
    .DEPTH (DEPTH)
  ) dut (
    .z_clk  (z_clk),
    .z_rst  (z_rst),
    .zi_vld (zi_vld),
    .zi_bus (zi_bus),
    .zi_ack (zi_ack),
    .zo_vld (zo_vld),
    .zo_bus (zo_bus),
    .zo_ack (zo_ack),
    .z_cnt  (z_cnt)
  );

  initial z_clk = 1'b0;
  always #5 z_clk = ~z_clk;

  // Advance one clock with the current inputs and update the reference queue.
  task automatic tick();
    bit w;
    bit r;
    w = zi_vld && (model_q.size() != DEPTH);
    r = (model_q.size() != 0) && zo_ack;
    @(posedge z_clk);
    if (z_rst) begin
      model_q.delete();
    end else begin
      if (r) void'(model_q.pop_front());
      if (w) model_q.push_back(zi_bus);
    end
    @(negedge z_clk);
  endtask

  task automatic test_reset();
    z_rst = 1'b1; zi_vld = 1'b0; zo_ack = 1'b0; zi_bus = '0;
    tick();
    z_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (zo_vld !== 1'b0 || zi_ack !== 1'b1 || z_cnt !== 3'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got vld=%b ack=%b cnt=%0d want vld=0 ack=1 cnt=0",
                 i, zo_vld, zi_ack, z_cnt);
      end
      tick();
    end
  endtask

  task automatic test_single();
    zi_vld = 1'b1; zi_bus = 8'hA5; zo_ack = 1'b0;
    // Not visible on the push cycle itself.
    checks++;
    if (zo_vld !== 1'b0) begin
      failures++;
      $display("FAIL single_nofallthru got vld=%b want 0", zo_vld);
    end
    tick();
    zi_vld = 1'b0;
    checks++;
    if (zo_vld !== 1'b1 || zo_bus !== 8'hA5 || z_cnt !== 3'd1) begin
      failures++;
      $display("FAIL single_push got vld=%b bus=%h cnt=%0d want vld=1 bus=a5 cnt=1",
               zo_vld, zo_bus, z_cnt);
    end
    zo_ack = 1'b1;
    $display("xfer out data=%h", zo_bus);
    tick();
    zo_ack = 1'b0;
    checks++;
    if (zo_vld !== 1'b0 || z_cnt !== 3'd0) begin
      failures++;
      $display("FAIL single_pop got vld=%b cnt=%0d want vld=0 cnt=0", zo_vld, z_cnt);
    end
  endtask

  task automatic test_fill();
    logic [BW-1:0] exp_seq [5];
    int idx;
    int cyc;
    bit sent5;
    for (int i = 0; i < 5; i++) exp_seq[i] = BW'(i + 1);
    zo_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      zi_vld = 1'b1; zi_bus = BW'(i);
      tick();
      checks++;
      if (z_cnt !== 3'(i)) begin
        failures++;
        $display("FAIL fill_cnt got %0d want %0d", z_cnt, i);
      end
    end
    checks++;
    if (zi_ack !== 1'b0) begin
      failures++;
      $display("FAIL fill_full_ack got %b want 0", zi_ack);
    end
    // Offer 0x05 while full: must be held.
    zi_vld = 1'b1; zi_bus = 8'h05;
    tick();
    checks++;
    if (z_cnt !== 3'd4 || zi_ack !== 1'b0) begin
      failures++;
      $display("FAIL fill_hold got cnt=%0d ack=%b want cnt=4 ack=0", z_cnt, zi_ack);
    end
    zo_ack = 1'b1;
    idx = 0; cyc = 0; sent5 = 0;
    while (idx < 5 && cyc < 20) begin
      checks++;
      if (zo_vld !== (model_q.size() != 0) || zi_ack !== (model_q.size() != DEPTH)) begin
        failures++;
        $display("FAIL fill_flags cyc=%0d got vld=%b ack=%b want vld=%b ack=%b", cyc,
                 zo_vld, zi_ack, model_q.size() != 0, model_q.size() != DEPTH);
      end
      if (cyc == 1) begin
        checks++;
        if (zi_ack !== 1'b1) begin
          failures++;
          $display("FAIL fill_ack_after_read got %b want 1", zi_ack);
        end
      end
      if (zo_vld && zo_ack) begin
        checks++;
        if (zo_bus !== exp_seq[idx]) begin
          failures++;
          $display("FAIL fill_order idx=%0d got %h want %h", idx, zo_bus, exp_seq[idx]);
        end
        $display("xfer out data=%h", zo_bus);
        idx++;
      end
      if (zi_vld && model_q.size() != DEPTH) sent5 = 1;
      tick();
      if (sent5) zi_vld = 1'b0;
      cyc++;
    end
    checks++;
    if (idx != 5) begin
      failures++;
      $display("FAIL fill_drain got %0d words want 5", idx);
    end
    zo_ack = 1'b0; zi_vld = 1'b0;
  endtask

  task automatic test_simul();
    zo_ack = 1'b0;
    zi_vld = 1'b1; zi_bus = 8'h10; tick();
    zi_bus = 8'h11; tick();
    checks++;
    if (z_cnt !== 3'd2) begin
      failures++;
      $display("FAIL simul_pre_cnt got %0d want 2", z_cnt);
    end
    zi_bus = 8'h12; zo_ack = 1'b1;
    $display("xfer out data=%h", zo_bus);
    tick();
    zi_vld = 1'b0;
    checks++;
    if (z_cnt !== 3'd2 || zo_bus !== 8'h11) begin
      failures++;
      $display("FAIL simul_rw got cnt=%0d bus=%h want cnt=2 bus=11", z_cnt, zo_bus);
    end
    $display("xfer out data=%h", zo_bus);
    tick();
    checks++;
    if (zo_vld !== 1'b1 || zo_bus !== 8'h12) begin
      failures++;
      $display("FAIL simul_tail got vld=%b bus=%h want vld=1 bus=12", zo_vld, zo_bus);
    end
    $display("xfer out data=%h", zo_bus);
    tick();
    zo_ack = 1'b0;
    checks++;
    if (zo_vld !== 1'b0 || z_cnt !== 3'd0) begin
      failures++;
      $display("FAIL simul_empty got vld=%b cnt=%0d want vld=0 cnt=0", zo_vld, z_cnt);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int recv;
    int cyc;
    void'($urandom(32'd1234));
    sent = 0; recv = 0; cyc = 0;
    while (recv < 20 && cyc < 400) begin
      // Upstream may drop vld without an ack; the FIFO must tolerate it.
      zi_vld = (sent < 20) && ($urandom_range(0, 3) != 0);
      zi_bus = BW'(sent);
      zo_ack = ($urandom_range(0, 1) == 1);
      checks++;
      if (z_cnt > 3'd4 || z_cnt !== 3'(model_q.size()) ||
          zo_vld !== (model_q.size() != 0) || zi_ack !== (model_q.size() != DEPTH)) begin
        failures++;
        $display("FAIL wrap_state cyc=%0d got cnt=%0d vld=%b ack=%b want cnt=%0d", cyc,
                 z_cnt, zo_vld, zi_ack, model_q.size());
      end
      if (zo_vld && zo_ack) begin
        checks++;
        if (zo_bus !== BW'(recv)) begin
          failures++;
          $display("FAIL wrap_order idx=%0d got %h want %h", recv, zo_bus, BW'(recv));
        end
        $display("xfer out data=%h", zo_bus);
        recv++;
      end
      if (zi_vld && model_q.size() != DEPTH) sent++;
      tick();
      cyc++;
    end
    zi_vld = 1'b0; zo_ack = 1'b0;
    checks++;
    if (recv != 20) begin
      failures++;
      $display("FAIL wrap_count got %0d words want 20", recv);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    zo_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      zi_vld = 1'b1; zi_bus = BW'(8'h30 + i);
      tick();
    end
    checks++;
    if (z_cnt !== 3'd3) begin
      failures++;
      $display("FAIL rstmid_pre_cnt got %0d want 3", z_cnt);
    end
    z_rst = 1'b1; zi_vld = 1'b1; zi_bus = 8'h77; zo_ack = 1'b1;
    tick();
    z_rst = 1'b0; zi_vld = 1'b0;
    checks++;
    if (z_cnt !== 3'd0 || zo_vld !== 1'b0 || zi_ack !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_after got cnt=%0d vld=%b ack=%b want cnt=0 vld=0 ack=1",
               z_cnt, zo_vld, zi_ack);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (zo_vld !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_ghost cyc=%0d got vld=%b bus=%h want vld=0", i, zo_vld, zo_bus);
      end
    end
    zo_ack = 1'b0; zi_vld = 1'b1; zi_bus = 8'h88;
    tick();
    zi_vld = 1'b0;
    cyc = 0;
    checks++;
    if (zo_vld !== 1'b1 || zo_bus !== 8'h88 || z_cnt !== 3'd1) begin
      failures++;
      $display("FAIL rstmid_next got vld=%b bus=%h cnt=%0d want vld=1 bus=88 cnt=1",
               zo_vld, zo_bus, z_cnt);
    end
    zo_ack = 1'b1;
    $display("xfer out data=%h", zo_bus);
    tick();
    zo_ack = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    z_rst = 1'b1; zi_vld = 1'b0; zi_bus = '0; zo_ack = 1'b0;
    @(negedge z_clk);
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zstr_fifo.md
Name: zstr_fifo

Overview:
Synchronous FIFO that terminates a zstr stream from an upstream producer (e.g. the zstr stimulus source in benches) and re-emits it as a zstr stream to a downstream consumer. It decouples producer and consumer timing and absorbs bursts up to DEPTH words. It is synthesizable and is used both in RTL datapaths and as the standard buffer in zbus benches.

Parameters:
BW, 1, width of the grouped bus z_bus carried per transfer
DEPTH, 4, number of storage entries; power of two, ≥2
AW, log2(DEPTH), pointer width; derived localparam, not overridable

Ports:
z_clk  input  1  system clock; all logic on the rising edge
z_rst  input  1  reset, synchronous, active-high
zi_vld  input  1  upstream transfer valid
zi_bus  input  BW  upstream grouped bus
zi_ack  output  1  upstream transfer acknowledge (FIFO not full)
zo_vld  output  1  downstream transfer valid (FIFO not empty)
zo_bus  output  BW  downstream grouped bus (head entry)
zo_ack  input  1  downstream transfer acknowledge
z_cnt  output  AW+1  current fill level, 0..DEPTH

Behaviour:
- Transfer rule on both sides: a word moves on a rising z_clk edge where vld & ack are both 1. No other condition moves data.
- Reset (z_rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, cnt=0. From the following cycle: zo_vld=0, zi_ack=1, z_cnt=0. Storage array is not reset; zo_bus is don't-care while zo_vld=0.
- Reset mid-operation discards all stored words immediately. Any transfer on that edge is ignored on both sides.
- zi_ack = (cnt != DEPTH); zo_vld = (cnt != 0). Both are decoded from registered state only. There is no combinational path from zi_vld/zo_ack to zi_ack/zo_vld.
- zo_bus = mem[rd_ptr], read combinationally from storage.
- Write (zi_vld & zi_ack): mem[wr_ptr] <= zi_bus; wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Read (zo_vld & zo_ack): rd_ptr increments modulo DEPTH.
- Count update: write only → cnt+1; read only → cnt−1; both or neither → unchanged.
- Latency: a word written at edge N is visible on zo_vld/zo_bus after edge N (one cycle), including when the FIFO was empty. There is no same-cycle fall-through.
- Full (cnt=DEPTH): zi_ack=0, so no write is accepted even if a read happens on the same edge. zi_ack rises the cycle after the read.
- Empty (cnt=0): zo_vld=0; a simultaneous write is accepted and appears on the next cycle.
- Simultaneous read and write at 0<cnt<DEPTH: both complete; cnt unchanged; order preserved.
- Ordering: strict FIFO. No word is duplicated or dropped.
- Throughput: one word per cycle sustained when 0<cnt<DEPTH.
- z_cnt equals cnt.
- Assertions (bench-only): no zi_vld deassertion before ack is required of upstream; the FIFO tolerates vld dropping without ack.

Decomposition:
- Shared zbus package holds the transfer-qualifier convention (vld & ack) and the clog2 helper used for AW. No typedefs are needed; the bus is an opaque BW vector.
- One natural sub-module: zstr_fifo_mem, a DEPTH×BW register array with synchronous write and asynchronous read. Pointer, count and handshake logic stay in zstr_fifo.

Test Plan:
- Reset then idle: after z_rst pulse → zo_vld=0, zi_ack=1, z_cnt=0 for all following cycles with zi_vld=0.
- Single word, DEPTH=4, BW=8: push 0xA5 with zo_ack=0 → zo_vld=1 and zo_bus=0xA5 one cycle later, z_cnt=1; then zo_ack=1 for one cycle → zo_vld=0, z_cnt=0.
- Fill to full: push 0x01..0x04 with zo_ack=0 → z_cnt=4, zi_ack=0; 0x05 is held (not accepted). Then zo_ack=1 → outputs 0x01,0x02,0x03,0x04,0x05 in order, and 0x05 is accepted the cycle after the first read.
- Simultaneous read/write at cnt=2: one edge with both transfers → z_cnt stays 2 and the output sequence is unchanged in order.
- Pointer wrap: stream 20 words 0x00..0x13 with random zo_ack (seeded) → all 20 received in order, none lost, z_cnt never exceeds 4.
- Reset mid-stream: at cnt=3 assert z_rst with zi_vld=1 and zo_ack=1 → next cycle z_cnt=0, zo_vld=0; the word presented on the reset edge is not later emitted.
